// File: rtl/uart_pkg.sv
// Shared UART definitions: handshake FSM encodings, FIFO depth and FCR bit positions.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;
  localparam int FCR_FIFO_EN     = 0;
  localparam int FCR_TX_CLR      = 2;

  typedef enum logic {
    TXF_IDLE = 1'b0,
    TXF_BUSY = 1'b1
  } txf_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a run-time capacity limit (cap_i) and a synchronous clear.
// Shared by the TX and RX paths; DEPTH must be a power of two.
module uart_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              bclk_in,
  input  logic              rstn_in,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              clr_i,
  input  logic [LW-1:0]     cap_i,
  output logic [DATA_W-1:0] head_o,
  output logic [LW-1:0]     level_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q >= cap_i);
  assign pop_ok  = pop_i && !empty_o;
  // A push into a full FIFO is still legal when a pop frees a slot on the same edge.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
    else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
  end

  always_ff @(posedge bclk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART TX holding stage: queues THR writes, hands the head byte to the shift stage
// and derives THRE/TEMT, fill level and write-drop status.
//   state    | meaning
//   TXF_IDLE | shift stage free; head byte offered when storage is non-empty
//   TXF_BUSY | a byte was handed over; waiting for shift_done or a ready timeout
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = UART_FIFO_DEPTH,
  parameter  int DATA_W = 8,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              bclk_in,
  input  logic              rstn_in,
  input  logic              fifo_en_in,
  input  logic              tx_clr_in,
  input  logic              wr_en_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              thr_valid_out,
  output logic [DATA_W-1:0] thr_out,
  input  logic              shift_ready_in,
  input  logic              shift_done_in,
  output logic              thre_out,
  output logic              temt_out,
  output logic [LW-1:0]     level_out,
  output logic              wr_drop_out
);

  txf_state_e        state_q;
  logic              rdy_tmr_q;
  logic              fifo_en_q;
  logic              drop_q;
  logic [LW-1:0]     cap;
  logic [LW-1:0]     level;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic              flush;
  logic              pop;
  logic              push;
  logic              drop;

  assign cap   = fifo_en_in ? LW'(DEPTH) : LW'(1);
  // Switching FIFO mode invalidates stored data just like an explicit TX clear.
  assign flush = tx_clr_in | (fifo_en_in ^ fifo_en_q);
  assign push  = wr_en_in && !flush;
  assign pop   = thr_valid_out && shift_ready_in;
  assign drop  = push && full && !pop;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .bclk_in (bclk_in),
    .rstn_in (rstn_in),
    .push_i  (push),
    .data_i  (wr_data_in),
    .pop_i   (pop),
    .clr_i   (flush),
    .cap_i   (cap),
    .head_o  (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Ready seen high for two BUSY cycles without a done means the shift stage was stopped.
  always_ff @(posedge bclk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q   <= TXF_IDLE;
      rdy_tmr_q <= 1'b1;
      fifo_en_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      fifo_en_q <= fifo_en_in;
      drop_q    <= drop;
      case (state_q)
        TXF_IDLE: begin
          if (pop) begin
            state_q   <= TXF_BUSY;
            rdy_tmr_q <= 1'b1;
          end
        end
        TXF_BUSY: begin
          if (shift_done_in)          state_q   <= TXF_IDLE;
          else if (!shift_ready_in)   rdy_tmr_q <= 1'b1;
          else if (rdy_tmr_q == 1'b0) state_q   <= TXF_IDLE;
          else                        rdy_tmr_q <= rdy_tmr_q - 1'b1;
        end
        default: state_q <= TXF_IDLE;
      endcase
    end
  end

  assign thr_valid_out = !empty && (state_q == TXF_IDLE);
  assign thr_out       = head;
  assign level_out     = level;
  assign thre_out      = empty;
  assign temt_out      = empty && (state_q == TXF_IDLE);
  assign wr_drop_out   = drop_q;

endmodule
